dsp_mult_sched: RTL and testbench



---
 rtl/dsp_mult_sched.sv | 187 ++++++++++++++++++
 tb/tb_dsp_mult_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mult_sched.sv
// dsp_mult_sched: round-robin sharing of one DSP multiplier between two 8x8 unsigned
// requesters. Issued ops are tagged through the DSP latency. Results land in per-channel
// FIFOs, and issue is credit-gated so a full FIFO can never be overrun.
// Optional feature: define DSP_MULT_SCHED_STATS_EN to add saturating per-channel
// accept counters (stat0_grants_o / stat1_grants_o).
module dsp_mult_sched #(
  parameter int unsigned DSP_LAT   = 1,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [7:0]  req0_a_i,
  input  logic [7:0]  req0_b_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [7:0]  req1_a_i,
  input  logic [7:0]  req1_b_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [15:0] rsp0_z_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [15:0] rsp1_z_o,
  output logic [9:0]  dsp_a_o,
  output logic [8:0]  dsp_b_o,
  input  logic [31:0] dsp_z_i
`ifdef DSP_MULT_SCHED_STATS_EN
  ,
  output logic [15:0] stat0_grants_o,
  output logic [15:0] stat1_grants_o
`endif
);

  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [1:0]         req_valid;
  logic [1:0]         rsp_ready;
  logic [1:0]         elig;
  logic [1:0]         grant;
  logic [1:0]         wr;
  logic [1:0]         pop;
  logic [1:0]         rsp_valid;
  logic [7:0]         req_a [2];
  logic [7:0]         req_b [2];
  logic [3:0]         cred [2];
  logic [3:0]         cnt [2];
  logic [PW-1:0]      wr_ptr [2];
  logic [PW-1:0]      rd_ptr [2];
  logic [15:0]        mem [2][RSP_DEPTH];
  logic [15:0]        rsp_z [2];
  logic               last;
  logic [DSP_LAT-1:0] tag_v;
  logic [DSP_LAT-1:0] tag_c;
  logic               unused_z_hi;

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};
  assign req_a[0]  = req0_a_i;
  assign req_a[1]  = req1_a_i;
  assign req_b[0]  = req0_b_i;
  assign req_b[1]  = req1_b_i;

  // Upper product bits are never needed for 8x8 operands.
  assign unused_z_hi = ^dsp_z_i[31:16];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    if (p == PW'(RSP_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Eligibility and round-robin grant; forced low while reset is held.
  always_comb begin
    elig  = '0;
    grant = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] && (cred[i] != 4'd0);
    end
    if (!reset_i) begin
      grant[0] = elig[0] && (!elig[1] || last);
      grant[1] = elig[1] && (!elig[0] || !last);
    end
  end

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  // Operand mux toward the DSP; zero when nothing is issued.
  always_comb begin
    dsp_a_o = '0;
    dsp_b_o = '0;
    if (grant[0]) begin
      dsp_a_o = {2'b00, req_a[0]};
      dsp_b_o = {1'b0, req_b[0]};
    end else if (grant[1]) begin
      dsp_a_o = {2'b00, req_a[1]};
      dsp_b_o = {1'b0, req_b[1]};
    end
  end

  // Tag pipeline matching the DSP latency; its last stage steers the result write.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tag_v <= '0;
      tag_c <= '0;
    end else begin
      tag_v[0] <= |grant;
      tag_c[0] <= grant[1];
      for (int k = 1; k < DSP_LAT; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_c[k] <= tag_c[k-1];
      end
    end
  end

  // FIFO write/pop strobes and head presentation (no same-cycle bypass).
  always_comb begin
    wr[0] = tag_v[DSP_LAT-1] && !tag_c[DSP_LAT-1];
    wr[1] = tag_v[DSP_LAT-1] && tag_c[DSP_LAT-1];
    for (int i = 0; i < 2; i++) begin
      rsp_valid[i] = (cnt[i] != 4'd0);
      pop[i]       = rsp_valid[i] && rsp_ready[i];
      rsp_z[i]     = rsp_valid[i] ? mem[i][rd_ptr[i]] : 16'h0000;
    end
  end

  assign rsp0_valid_o = rsp_valid[0];
  assign rsp1_valid_o = rsp_valid[1];
  assign rsp0_z_o     = rsp_z[0];
  assign rsp1_z_o     = rsp_z[1];

  // FIFO pointers, occupancy and issue credits; credit returns on pop, one cycle late.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= 4'd0;
        cred[i]   <= 4'(RSP_DEPTH);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr[i]) wr_ptr[i] <= bump(wr_ptr[i]);
        if (pop[i]) rd_ptr[i] <= bump(rd_ptr[i]);
        cnt[i]  <= cnt[i] + {3'b000, wr[i]} - {3'b000, pop[i]};
        cred[i] <= cred[i] - {3'b000, grant[i]} + {3'b000, pop[i]};
      end
    end
  end

  // FIFO storage; contents are don't-care until the occupancy count covers them.
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < 2; i++) begin
      if (wr[i]) mem[i][wr_ptr[i]] <= dsp_z_i[15:0];
    end
  end

  // Round-robin pointer; reset to 1 so channel 0 wins the first tie.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      last <= 1'b1;
    end else if (|grant) begin
      last <= grant[1];
    end
  end

`ifdef DSP_MULT_SCHED_STATS_EN
  logic [15:0] stat [2];

  // Saturating accept counters per channel.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      stat[0] <= 16'h0000;
      stat[1] <= 16'h0000;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i] && (stat[i] != 16'hFFFF)) stat[i] <= stat[i] + 16'h0001;
      end
    end
  end

  assign stat0_grants_o = stat[0];
  assign stat1_grants_o = stat[1];
`endif

endmodule

// File: tb/tb_dsp_mult_sched.sv
// Self-checking bench for dsp_mult_sched: vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_dsp_mult_sched;

  localparam int unsigned LAT = 1;
`ifdef DSP_MULT_SCHED_STATS_EN
  localparam int unsigned DEPTH = 4;
`else
  localparam int unsigned DEPTH = 2;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [15:0] rsp0_z, rsp1_z;
  logic [9:0]  dsp_a;
  logic [8:0]  dsp_b;
  logic [31:0] dsp_z;
  logic [15:0] junk_hi = 16'h0000;
  logic [15:0] pipe [LAT];
`ifdef DSP_MULT_SCHED_STATS_EN
  logic [15:0] stat0, stat1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        last_m = 1'b1;
  int          acc0 = 0;
  int          acc1 = 0;

  always #5 clock = ~clock;

  dsp_mult_sched #(.DSP_LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .rsp0_valid_o (rsp0_valid),
    .rsp0_ready_i (rsp0_ready),
    .rsp0_z_o     (rsp0_z),
    .rsp1_valid_o (rsp1_valid),
    .rsp1_ready_i (rsp1_ready),
    .rsp1_z_o     (rsp1_z),
    .dsp_a_o      (dsp_a),
    .dsp_b_o      (dsp_b),
    .dsp_z_i      (dsp_z)
`ifdef DSP_MULT_SCHED_STATS_EN
    ,
    .stat0_grants_o (stat0),
    .stat1_grants_o (stat1)
`endif
  );

  // DSP stand-in: inputs registered, product available LAT cycles after capture.
  always @(posedge clock) begin
    logic [18:0] p;
    p = 19'(dsp_a) * 19'(dsp_b);
    pipe[0] <= p[15:0];
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign dsp_z = {junk_hi, pipe[LAT-1]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding ops per channel = in-flight + buffered, so the
  // credit is DEPTH minus queue length; grants follow the round-robin rules.
  always @(negedge clock) begin
    logic e0, e1, g0, g1;
    if (reset) begin
      q0.delete();
      q1.delete();
      last_m = 1'b1;
      acc0   = 0;
      acc1   = 0;
    end else begin
      e0 = req0_valid && (q0.size() < int'(DEPTH));
      e1 = req1_valid && (q1.size() < int'(DEPTH));
      g0 = e0 && (!e1 || last_m);
      g1 = e1 && (!e0 || !last_m);
      check("model_ready0", 32'(req0_ready), 32'(g0));
      check("model_ready1", 32'(req1_ready), 32'(g1));
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) check("rsp0_unexpected_pop", 32'(rsp0_z), 32'hFFFF_FFFF);
        else check("model_rsp0_z", 32'(rsp0_z), 32'(q0.pop_front()));
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) check("rsp1_unexpected_pop", 32'(rsp1_z), 32'hFFFF_FFFF);
        else check("model_rsp1_z", 32'(rsp1_z), 32'(q1.pop_front()));
      end
      if (req0_valid && req0_ready) begin
        q0.push_back(16'(req0_a) * 16'(req0_b));
        last_m = 1'b0;
        acc0++;
      end
      if (req1_valid && req1_ready) begin
        q1.push_back(16'(req1_a) * 16'(req1_b));
        last_m = 1'b1;
        acc1++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready0"}, 32'(req0_ready), 0);
    check({tag, "_ready1"}, 32'(req1_ready), 0);
    check({tag, "_rsp0_valid"}, 32'(rsp0_valid), 0);
    check({tag, "_rsp1_valid"}, 32'(rsp1_valid), 0);
    check({tag, "_rsp0_z"}, 32'(rsp0_z), 0);
    check({tag, "_rsp1_z"}, 32'(rsp1_z), 0);
    check({tag, "_dsp_a"}, 32'(dsp_a), 0);
    check({tag, "_dsp_b"}, 32'(dsp_b), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("rst");
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic idle_drain(input int cycles);
    req0_valid = 0;
    req1_valid = 0;
    rsp0_ready = 1;
    rsp1_ready = 1;
    repeat (cycles) next_cycle();
  endtask

  typedef struct {
    logic        ch;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] z;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int cnt1;
    tbl[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    tbl[1] = '{1'b1, 8'h80, 8'h02, 16'h0100};
    tbl[2] = '{1'b0, 8'h00, 8'h37, 16'h0000};
    tbl[3] = '{1'b1, 8'h12, 8'h34, 16'h03A8};
    tbl[4] = '{1'b0, 8'h0F, 8'h11, 16'h00FF};
    tbl[5] = '{1'b1, 8'hFF, 8'h01, 16'h00FF};
    tbl[6] = '{1'b0, 8'h10, 8'h10, 16'h0100};
    tbl[7] = '{1'b1, 8'hFF, 8'hFF, 16'hFE01};

    // Power-on reset with requests pending: grants must stay low.
    req0_valid = 1;
    req1_valid = 1;
    @(negedge clock);
    check_reset_outputs("por");
    req0_valid = 0;
    req1_valid = 0;
    next_cycle();
    reset = 1'b0;

    // Single ops from the table; upper DSP bits carry junk that must be ignored.
    junk_hi    = 16'hABCD;
    rsp0_ready = 1;
    rsp1_ready = 1;
    for (int v = 0; v < 8; v++) begin
      if (tbl[v].ch == 1'b0) begin
        req0_valid = 1; req0_a = tbl[v].a; req0_b = tbl[v].b;
      end else begin
        req1_valid = 1; req1_a = tbl[v].a; req1_b = tbl[v].b;
      end
      @(negedge clock);
      check("vec_ready_sel", 32'(tbl[v].ch ? req1_ready : req0_ready), 1);
      check("vec_ready_other", 32'(tbl[v].ch ? req0_ready : req1_ready), 0);
      check("vec_dsp_a", 32'(dsp_a), 32'({2'b00, tbl[v].a}));
      check("vec_dsp_b", 32'(dsp_b), 32'({1'b0, tbl[v].b}));
      next_cycle();
      req0_valid = 0;
      req1_valid = 0;
      for (int c = 1; c <= int'(LAT); c++) begin
        @(negedge clock);
        check("vec_no_bypass", 32'(tbl[v].ch ? rsp1_valid : rsp0_valid), 0);
        next_cycle();
      end
      @(negedge clock);
      check("vec_rsp_valid", 32'(tbl[v].ch ? rsp1_valid : rsp0_valid), 1);
      check("vec_rsp_z", 32'(tbl[v].ch ? rsp1_z : rsp0_z), 32'(tbl[v].z));
      next_cycle();
    end
    idle_drain(3);

    // Tie-break: alternating grants starting with channel 0.
    do_reset();
    rsp0_ready = 1;
    rsp1_ready = 1;
    req0_valid = 1;
    req1_valid = 1;
    for (int i = 0; i < 8; i++) begin
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      @(negedge clock);
      check("tie_ready0", 32'(req0_ready), 32'(i % 2 == 0));
      check("tie_ready1", 32'(req1_ready), 32'(i % 2 == 1));
      next_cycle();
    end
    idle_drain(6);

    // Backpressure on channel 1: exactly DEPTH accepts, channel 0 keeps flowing.
    do_reset();
    rsp0_ready = 1;
    rsp1_ready = 0;
    req0_valid = 1;
    req1_valid = 1;
    cnt1 = 0;
    for (int i = 0; i < 12; i++) begin
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      @(negedge clock);
      if (req1_ready) cnt1++;
      if (i == 11) begin
        check("bp_ready0_flowing", 32'(req0_ready), 1);
        check("bp_ready1_blocked", 32'(req1_ready), 0);
      end
      next_cycle();
    end
    check("bp_accept_count", 32'(cnt1), 32'(DEPTH));
    rsp1_ready = 1;
    @(negedge clock);
    check("bp_head_valid", 32'(rsp1_valid), 1);
    check("bp_no_early_grant", 32'(req1_ready), 0);
    next_cycle();
    @(negedge clock);
    check("bp_resume_grant", 32'(req1_ready), 1);
    next_cycle();
    idle_drain(10);
    check("bp_drain_q0", 32'(q0.size()), 0);
    check("bp_drain_q1", 32'(q1.size()), 0);

    // Reset mid-flight: the 3x5 product must never surface.
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 8'd3; req0_b = 8'd5;
    @(negedge clock);
    check("mf_accept", 32'(req0_ready), 1);
    next_cycle();
    reset      = 1'b1;
    req1_valid = 1;
    #1;
    check_reset_outputs("mf");
    next_cycle();
    reset      = 1'b0;
    req0_valid = 0;
    req1_valid = 0;
    rsp0_ready = 1;
    for (int c = 0; c < int'(LAT) + 3; c++) begin
      @(negedge clock);
      check("mf_no_result", 32'(rsp0_valid), 0);
      next_cycle();
    end
    rsp0_ready = 0;
    req0_valid = 1;
    cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (req0_ready) cnt1++;
      next_cycle();
    end
    check("mf_credits", 32'(cnt1), 32'(DEPTH));
    idle_drain(8);

    // Randomized traffic checked by the reference model.
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      rsp0_ready = ($urandom_range(0, 9) < 6);
      rsp1_ready = ($urandom_range(0, 9) < 6);
      junk_hi    = 16'($urandom);
      next_cycle();
    end
    idle_drain(20);
    check("rand_drain_q0", 32'(q0.size()), 0);
    check("rand_drain_q1", 32'(q1.size()), 0);

`ifdef DSP_MULT_SCHED_STATS_EN
    do_reset();
    @(negedge clock);
    check("stat0_reset", 32'(stat0), 0);
    check("stat1_reset", 32'(stat1), 0);
    next_cycle();
    rsp0_ready = 1;
    req0_valid = 1;
    for (int i = 0; i < 70005; i++) begin
      if (i == 10) begin
        @(negedge clock);
        check("stat0_partial", 32'(stat0), 32'(acc0 - (req0_ready ? 1 : 0)));
      end
      next_cycle();
    end
    req0_valid = 0;
    @(negedge clock);
    check("stat0_enough_accepts", 32'(acc0 >= 65535), 1);
    check("stat0_saturated", 32'(stat0), 32'h0000_FFFF);
    check("stat1_zero", 32'(stat1), 0);
    idle_drain(4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
